// File: rtl/correlation_sequencer.sv
// Sequencer for the three-channel correlator: capture one frame, pace the
// correlator trigger to the buffer read latency, report signed lags.
module correlation_sequencer #(
  parameter int WINDOW_WIDTH  = 150,
  parameter int MAX_DEVIATION = 30,
  parameter int READ_LATENCY  = 1,
  parameter int TIMEOUT       = 32768
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              sample_valid_i,
  output logic              capture_en_o,
  output logic [7:0]        capture_addr_o,
  output logic              corr_reset_o,
  output logic              corr_trigger_o,
  input  logic              corr_done_i,
  input  logic [7:0]        corr_offset_1_i,
  input  logic [7:0]        corr_offset_2_i,
  output logic signed [8:0] delay_1_o,
  output logic signed [8:0] delay_2_o,
  output logic              result_valid_o,
  input  logic              result_ack_i,
  output logic              busy_o,
  output logic              timeout_err_o
);

  localparam int                CAPTURE_LEN = WINDOW_WIDTH + 2 * MAX_DEVIATION + 1;
  localparam logic [7:0]        LAST_ADDR   = 8'(CAPTURE_LEN - 1);
  localparam logic [1:0]        PHASE_MAX   = 2'(READ_LATENCY);
  localparam logic [15:0]       TMO_LAST    = 16'(TIMEOUT - 1);
  localparam logic signed [8:0] DEV         = 9'(MAX_DEVIATION);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_RUN,
    S_REPORT
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         addr_q, addr_d;
  logic [1:0]         phase_q, phase_d;
  logic [15:0]        tmo_q, tmo_d;
  logic signed [8:0]  dly1_q, dly1_d;
  logic signed [8:0]  dly2_q, dly2_d;
  logic               err_q, err_d;
  logic               trigger;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    tmo_d   = tmo_q;
    dly1_d  = dly1_q;
    dly2_d  = dly2_q;
    err_d   = err_q;
    trigger = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CAPTURE;
          addr_d  = 8'd0;
          err_d   = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (sample_valid_i) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_RUN;
            phase_d = 2'd0;
            tmo_d   = 16'd0;
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end
      end
      S_RUN: begin
        // The step lands one read latency after the correlator presents its address.
        trigger = (phase_q == PHASE_MAX) && !corr_done_i;
        phase_d = (phase_q == PHASE_MAX) ? 2'd0 : phase_q + 2'd1;
        tmo_d   = tmo_q + 16'd1;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (corr_done_i) begin
          dly1_d  = $signed({1'b0, corr_offset_1_i}) - DEV;
          dly2_d  = $signed({1'b0, corr_offset_2_i}) - DEV;
          state_d = S_REPORT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_REPORT: begin
        if (abort_i || result_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      addr_q  <= 8'd0;
      phase_q <= 2'd0;
      tmo_q   <= 16'd0;
      dly1_q  <= 9'sd0;
      dly2_q  <= 9'sd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      tmo_q   <= tmo_d;
      dly1_q  <= dly1_d;
      dly2_q  <= dly2_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from the state register so reset takes effect at once.
  assign capture_en_o   = (state_q == S_CAPTURE);
  assign corr_reset_o   = (state_q != S_RUN);
  assign corr_trigger_o = trigger;
  assign result_valid_o = (state_q == S_REPORT);
  assign busy_o         = (state_q != S_IDLE);
  assign capture_addr_o = addr_q;
  assign delay_1_o      = dly1_q;
  assign delay_2_o      = dly2_q;
  assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_correlation_sequencer.sv
// Directed bench for correlation_sequencer; results checked through a
// scoreboard queue popped by an independent monitor.
module tb_correlation_sequencer;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              start_i, abort_i, sample_valid_i;
  logic              capture_en_o;
  logic [7:0]        capture_addr_o;
  logic              corr_reset_o, corr_trigger_o;
  logic              corr_done_i;
  logic [7:0]        corr_offset_1_i, corr_offset_2_i;
  logic signed [8:0] delay_1_o, delay_2_o;
  logic              result_valid_o, result_ack_i;
  logic              busy_o, timeout_err_o;

  typedef struct {
    logic [8:0] d1;
    logic [8:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic seen  = 1'b0;

  correlation_sequencer #(
    .WINDOW_WIDTH (150),
    .MAX_DEVIATION(30),
    .READ_LATENCY (2),
    .TIMEOUT      (100)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .sample_valid_i (sample_valid_i),
    .capture_en_o   (capture_en_o),
    .capture_addr_o (capture_addr_o),
    .corr_reset_o   (corr_reset_o),
    .corr_trigger_o (corr_trigger_o),
    .corr_done_i    (corr_done_i),
    .corr_offset_1_i(corr_offset_1_i),
    .corr_offset_2_i(corr_offset_2_i),
    .delay_1_o      (delay_1_o),
    .delay_2_o      (delay_2_o),
    .result_valid_o (result_valid_o),
    .result_ack_i   (result_ack_i),
    .busy_o         (busy_o),
    .timeout_err_o  (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue start (optionally) and deliver n sample strobes, with a gap every 10th.
  task automatic capture(input int n, input bit do_start);
    if (do_start) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("cap_en_on", {31'b0, capture_en_o}, 32'd1);
    end
    for (int i = 0; i < n; i++) begin
      if (i % 10 == 9) begin
        sample_valid_i = 1'b0;
        tick();
      end
      sample_valid_i = 1'b1;
      tick();
    end
    sample_valid_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (result_valid_o && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got d1=%h d2=%h expected none", delay_1_o, delay_2_o);
      end else begin
        e = exp_q.pop_front();
        check("res_delay_1", {23'b0, delay_1_o}, {23'b0, e.d1});
        check("res_delay_2", {23'b0, delay_2_o}, {23'b0, e.d2});
      end
    end else if (!result_valid_o) begin
      seen = 1'b0;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_ni        = 1'b0;
    start_i         = 1'b0;
    abort_i         = 1'b0;
    sample_valid_i  = 1'b0;
    corr_done_i     = 1'b0;
    corr_offset_1_i = 8'd0;
    corr_offset_2_i = 8'd0;
    result_ack_i    = 1'b0;
    #12;
    check("rst_busy",      {31'b0, busy_o},         32'd0);
    check("rst_corr_rst",  {31'b0, corr_reset_o},   32'd1);
    check("rst_cap_en",    {31'b0, capture_en_o},   32'd0);
    check("rst_addr",      {24'b0, capture_addr_o}, 32'd0);
    check("rst_trigger",   {31'b0, corr_trigger_o}, 32'd0);
    check("rst_valid",     {31'b0, result_valid_o}, 32'd0);
    check("rst_delay_1",   {23'b0, delay_1_o},      32'd0);
    check("rst_delay_2",   {23'b0, delay_2_o},      32'd0);
    check("rst_tmo_err",   {31'b0, timeout_err_o},  32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();

    // Nominal run with trigger pacing at read latency 2.
    capture(211, 1'b1);
    check("run_corr_rst", {31'b0, corr_reset_o},   32'd0);
    check("run_cap_en",   {31'b0, capture_en_o},   32'd0);
    check("run_addr",     {24'b0, capture_addr_o}, 32'd210);
    for (int k = 0; k < 14; k++) begin
      check($sformatf("pace_k%0d", k), {31'b0, corr_trigger_o}, (k % 3 == 2) ? 32'd1 : 32'd0);
      tick();
    end
    corr_done_i     = 1'b1;
    corr_offset_1_i = 8'd30;
    corr_offset_2_i = 8'd45;
    exp_q.push_back('{d1: 9'h000, d2: 9'h00F});
    #1;
    check("trig_off_on_done", {31'b0, corr_trigger_o}, 32'd0);
    tick();
    corr_done_i = 1'b0;
    check("rep_valid", {31'b0, result_valid_o}, 32'd1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_in_report", {31'b0, result_valid_o}, 32'd1);
    check("rep_hold_d2",     {23'b0, delay_2_o},      32'h00F);
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;
    check("ack_valid", {31'b0, result_valid_o}, 32'd0);
    check("ack_idle",  {31'b0, busy_o},         32'd0);

    // Negative lag, ack in the same cycle valid rises.
    capture(211, 1'b1);
    repeat (5) tick();
    corr_done_i     = 1'b1;
    corr_offset_1_i = 8'd0;
    corr_offset_2_i = 8'd60;
    exp_q.push_back('{d1: 9'h1E2, d2: 9'h01E});
    tick();
    corr_done_i  = 1'b0;
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;
    check("early_ack_idle", {31'b0, busy_o},         32'd0);
    check("early_ack_vld",  {31'b0, result_valid_o}, 32'd0);

    // Timeout after exactly 100 RUN cycles.
    capture(211, 1'b1);
    repeat (99) tick();
    check("tmo_pre_busy", {31'b0, busy_o},        32'd1);
    check("tmo_pre_err",  {31'b0, timeout_err_o}, 32'd0);
    tick();
    check("tmo_busy",  {31'b0, busy_o},         32'd0);
    check("tmo_err",   {31'b0, timeout_err_o},  32'd1);
    check("tmo_valid", {31'b0, result_valid_o}, 32'd0);

    // Restart clears the error; abort mid-capture.
    capture(50, 1'b1);
    check("restart_err", {31'b0, timeout_err_o},  32'd0);
    check("abort_addr",  {24'b0, capture_addr_o}, 32'd50);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy",   {31'b0, busy_o},       32'd0);
    check("abort_cap_en", {31'b0, capture_en_o}, 32'd0);
    check("abort_c_rst",  {31'b0, corr_reset_o}, 32'd1);
    check("abort_hold",   {23'b0, delay_1_o},    32'h1E2);

    // Abort beats done in RUN.
    capture(211, 1'b1);
    repeat (3) tick();
    corr_done_i     = 1'b1;
    abort_i         = 1'b1;
    corr_offset_1_i = 8'd10;
    corr_offset_2_i = 8'd10;
    tick();
    corr_done_i = 1'b0;
    abort_i     = 1'b0;
    check("abdone_busy",  {31'b0, busy_o},         32'd0);
    check("abdone_valid", {31'b0, result_valid_o}, 32'd0);
    check("abdone_hold",  {23'b0, delay_2_o},      32'h01E);
    repeat (2) tick();

    // Start wins over abort in IDLE; then async reset during RUN.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_busy", {31'b0, busy_o}, 32'd1);
    capture(211, 1'b0);
    repeat (4) tick();
    #2;
    reset_ni = 1'b0;
    #1;
    check("arst_busy",    {31'b0, busy_o},         32'd0);
    check("arst_c_rst",   {31'b0, corr_reset_o},   32'd1);
    check("arst_addr",    {24'b0, capture_addr_o}, 32'd0);
    check("arst_delay_1", {23'b0, delay_1_o},      32'd0);
    #4;
    reset_ni = 1'b1;
    repeat (3) tick();
    check("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
